// File: rtl/switch_mcu_ahb_arb.sv
// Two-requester AHB-Lite master arbiter: instruction fetch (port 0) and load/store (port 1)
// share one core-side master port, one non-pipelined single transfer at a time.
module switch_mcu_ahb_arb #(
    parameter bit         PRIO_MODE = 1'b0,
    parameter logic [3:0] MAX_WAIT  = 4'd8
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_init_done,
    input  logic        in_m0_req,
    input  logic [31:0] in_m0_addr,
    input  logic        in_m0_write,
    input  logic [2:0]  in_m0_size,
    input  logic [31:0] in_m0_wdata,
    output logic        out_m0_ack,
    output logic [31:0] out_m0_rdata,
    output logic        out_m0_err,
    input  logic        in_m1_req,
    input  logic [31:0] in_m1_addr,
    input  logic        in_m1_write,
    input  logic [2:0]  in_m1_size,
    input  logic [31:0] in_m1_wdata,
    output logic        out_m1_ack,
    output logic [31:0] out_m1_rdata,
    output logic        out_m1_err,
    input  logic        in_hready,
    input  logic        in_hresp,
    input  logic [31:0] in_hrdata,
    output logic [31:0] out_haddr,
    output logic [1:0]  out_htrans,
    output logic        out_hwrite,
    output logic [2:0]  out_hsize,
    output logic [2:0]  out_hburst,
    output logic [3:0]  out_hport,
    output logic        out_hmastlock,
    output logic [31:0] out_hwdata,
    output logic        out_owner
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t      r_state, w_nextState;
    logic [3:0]  r_waitCnt, w_waitCnt;
    logic [31:0] r_haddr, w_haddr;
    logic [1:0]  r_htrans, w_htrans;
    logic        r_hwrite, w_hwrite;
    logic [2:0]  r_hsize, w_hsize;
    logic [3:0]  r_hport, w_hport;
    logic [31:0] r_hwdata, w_hwdata;
    logic [31:0] r_wdataLat, w_wdataLat;
    logic        r_owner, w_owner;
    logic        r_ack0, w_ack0, r_ack1, w_ack1;
    logic        r_err0, w_err0, r_err1, w_err1;
    logic [31:0] r_rdata0, w_rdata0, r_rdata1, w_rdata1;
    logic        w_grant, w_winner;

    // Starvation guard outranks the configured policy; a lone requester always wins.
    always_comb begin
        w_grant = (r_state == IDLE) && in_init_done && (in_m0_req || in_m1_req);
        if (in_m0_req && (r_waitCnt == MAX_WAIT))
            w_winner = 1'b0;
        else if (!in_m0_req)
            w_winner = 1'b1;
        else if (!in_m1_req)
            w_winner = 1'b0;
        else if (PRIO_MODE)
            w_winner = ~r_owner;
        else
            w_winner = 1'b1;

        if (!in_m0_req || (w_grant && !w_winner))
            w_waitCnt = 4'd0;
        else if (r_waitCnt != MAX_WAIT)
            w_waitCnt = r_waitCnt + 4'd1;
        else
            w_waitCnt = r_waitCnt;
    end

    always_comb begin
        w_nextState = r_state;
        w_haddr     = r_haddr;
        w_htrans    = r_htrans;
        w_hwrite    = r_hwrite;
        w_hsize     = r_hsize;
        w_hport     = r_hport;
        w_hwdata    = r_hwdata;
        w_wdataLat  = r_wdataLat;
        w_owner     = r_owner;
        w_ack0      = 1'b0;
        w_ack1      = 1'b0;
        w_err0      = 1'b0;
        w_err1      = 1'b0;
        w_rdata0    = 32'd0;
        w_rdata1    = 32'd0;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_nextState = ADDR;
                    w_owner     = w_winner;
                    w_htrans    = 2'b10;
                    w_haddr     = w_winner ? in_m1_addr  : in_m0_addr;
                    w_hwrite    = w_winner ? in_m1_write : in_m0_write;
                    w_hsize     = w_winner ? in_m1_size  : in_m0_size;
                    w_wdataLat  = w_winner ? in_m1_wdata : in_m0_wdata;
                    w_hport     = w_winner ? 4'b0001 : 4'b0011;
                end
            end
            ADDR: begin
                if (in_hready) begin
                    w_nextState = DATA;
                    w_htrans    = 2'b00;
                    w_haddr     = 32'd0;
                    w_hwdata    = r_hwrite ? r_wdataLat : 32'd0;
                end
            end
            DATA: begin
                // The slave's first error cycle (hready low) is deliberately not sampled.
                if (in_hready) begin
                    w_nextState = IDLE;
                    w_hwdata    = 32'd0;
                    if (r_owner) begin
                        w_ack1   = 1'b1;
                        w_err1   = in_hresp;
                        w_rdata1 = r_hwrite ? 32'd0 : in_hrdata;
                    end else begin
                        w_ack0   = 1'b1;
                        w_err0   = in_hresp;
                        w_rdata0 = r_hwrite ? 32'd0 : in_hrdata;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_waitCnt  <= 4'd0;
            r_haddr    <= 32'd0;
            r_htrans   <= 2'b00;
            r_hwrite   <= 1'b0;
            r_hsize    <= 3'd0;
            r_hport    <= 4'd0;
            r_hwdata   <= 32'd0;
            r_wdataLat <= 32'd0;
            r_owner    <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
            r_rdata0   <= 32'd0;
            r_rdata1   <= 32'd0;
        end else begin
            r_waitCnt  <= w_waitCnt;
            r_haddr    <= w_haddr;
            r_htrans   <= w_htrans;
            r_hwrite   <= w_hwrite;
            r_hsize    <= w_hsize;
            r_hport    <= w_hport;
            r_hwdata   <= w_hwdata;
            r_wdataLat <= w_wdataLat;
            r_owner    <= w_owner;
            r_ack0     <= w_ack0;
            r_ack1     <= w_ack1;
            r_err0     <= w_err0;
            r_err1     <= w_err1;
            r_rdata0   <= w_rdata0;
            r_rdata1   <= w_rdata1;
        end
    end

    assign out_haddr     = r_haddr;
    assign out_htrans    = r_htrans;
    assign out_hwrite    = r_hwrite;
    assign out_hsize     = r_hsize;
    assign out_hburst    = 3'b000;
    assign out_hport     = r_hport;
    assign out_hmastlock = 1'b0;
    assign out_hwdata    = r_hwdata;
    assign out_owner     = r_owner;
    assign out_m0_ack    = r_ack0;
    assign out_m0_rdata  = r_rdata0;
    assign out_m0_err    = r_err0;
    assign out_m1_ack    = r_ack1;
    assign out_m1_rdata  = r_rdata1;
    assign out_m1_err    = r_err1;

endmodule

// File: tb/tb_switch_mcu_ahb_arb.sv
// Directed bench for switch_mcu_ahb_arb: a fixed-priority instance drives most tests,
// a round-robin instance checks alternating grants.
module tb_switch_mcu_ahb_arb;

    logic        in_clk, in_rst, in_init_done;
    logic        in_m0_req, in_m0_write, in_m1_req, in_m1_write;
    logic [31:0] in_m0_addr, in_m0_wdata, in_m1_addr, in_m1_wdata;
    logic [2:0]  in_m0_size, in_m1_size;
    logic        in_hready, in_hresp;
    logic [31:0] in_hrdata;
    logic        out_m0_ack, out_m0_err, out_m1_ack, out_m1_err;
    logic [31:0] out_m0_rdata, out_m1_rdata, out_haddr, out_hwdata;
    logic [1:0]  out_htrans;
    logic        out_hwrite, out_hmastlock, out_owner;
    logic [2:0]  out_hsize, out_hburst;
    logic [3:0]  out_hport;

    logic        rr_m0_req, rr_m1_req;
    logic        rr_m0_ack, rr_m0_err, rr_m1_ack, rr_m1_err;
    logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_haddr, rr_hwdata;
    logic [1:0]  rr_htrans;
    logic        rr_hwrite, rr_hmastlock, rr_owner;
    logic [2:0]  rr_hsize, rr_hburst;
    logic [3:0]  rr_hport;

    int compareCount = 0;
    int mismatchCount = 0;

    switch_mcu_ahb_arb #(.PRIO_MODE(1'b0), .MAX_WAIT(4'd8)) dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_init_done(in_init_done),
        .in_m0_req(in_m0_req), .in_m0_addr(in_m0_addr), .in_m0_write(in_m0_write),
        .in_m0_size(in_m0_size), .in_m0_wdata(in_m0_wdata),
        .out_m0_ack(out_m0_ack), .out_m0_rdata(out_m0_rdata), .out_m0_err(out_m0_err),
        .in_m1_req(in_m1_req), .in_m1_addr(in_m1_addr), .in_m1_write(in_m1_write),
        .in_m1_size(in_m1_size), .in_m1_wdata(in_m1_wdata),
        .out_m1_ack(out_m1_ack), .out_m1_rdata(out_m1_rdata), .out_m1_err(out_m1_err),
        .in_hready(in_hready), .in_hresp(in_hresp), .in_hrdata(in_hrdata),
        .out_haddr(out_haddr), .out_htrans(out_htrans), .out_hwrite(out_hwrite),
        .out_hsize(out_hsize), .out_hburst(out_hburst), .out_hport(out_hport),
        .out_hmastlock(out_hmastlock), .out_hwdata(out_hwdata), .out_owner(out_owner)
    );

    switch_mcu_ahb_arb #(.PRIO_MODE(1'b1), .MAX_WAIT(4'd8)) dutRr (
        .in_clk(in_clk), .in_rst(in_rst), .in_init_done(in_init_done),
        .in_m0_req(rr_m0_req), .in_m0_addr(in_m0_addr), .in_m0_write(in_m0_write),
        .in_m0_size(in_m0_size), .in_m0_wdata(in_m0_wdata),
        .out_m0_ack(rr_m0_ack), .out_m0_rdata(rr_m0_rdata), .out_m0_err(rr_m0_err),
        .in_m1_req(rr_m1_req), .in_m1_addr(in_m1_addr), .in_m1_write(in_m1_write),
        .in_m1_size(in_m1_size), .in_m1_wdata(in_m1_wdata),
        .out_m1_ack(rr_m1_ack), .out_m1_rdata(rr_m1_rdata), .out_m1_err(rr_m1_err),
        .in_hready(in_hready), .in_hresp(in_hresp), .in_hrdata(in_hrdata),
        .out_haddr(rr_haddr), .out_htrans(rr_htrans), .out_hwrite(rr_hwrite),
        .out_hsize(rr_hsize), .out_hburst(rr_hburst), .out_hport(rr_hport),
        .out_hmastlock(rr_hmastlock), .out_hwdata(rr_hwdata), .out_owner(rr_owner)
    );

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compareCount++;
        if (got !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic [31:0] addr,
                                 input logic write, input logic [31:0] wdata);
        if (port == 0) begin
            in_m0_req = req; in_m0_addr = addr; in_m0_write = write; in_m0_wdata = wdata;
        end else begin
            in_m1_req = req; in_m1_addr = addr; in_m1_write = write; in_m1_wdata = wdata;
        end
    endtask

    task automatic nextCycle();
        @(negedge in_clk);
    endtask

    // Owners expected at each successive grant with both ports held continuously.
    logic starveExp[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic rrExp[4]     = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int nGrants;
        in_rst = 1'b0; in_init_done = 1'b1;
        in_m0_req = 0; in_m0_addr = 0; in_m0_write = 0; in_m0_size = 3'd2; in_m0_wdata = 0;
        in_m1_req = 0; in_m1_addr = 0; in_m1_write = 0; in_m1_size = 3'd2; in_m1_wdata = 0;
        rr_m0_req = 0; rr_m1_req = 0;
        in_hready = 1'b1; in_hresp = 1'b0; in_hrdata = 32'h1234_5678;

        #1;
        checkOutput("reset_htrans", 32'(out_htrans), 32'd0);
        checkOutput("reset_haddr", out_haddr, 32'd0);
        checkOutput("reset_hport", 32'(out_hport), 32'd0);
        checkOutput("reset_owner", 32'(out_owner), 32'd0);
        checkOutput("reset_acks", 32'({out_m0_ack, out_m1_ack}), 32'd0);
        checkOutput("const_hburst_lock", 32'({out_hburst, out_hmastlock}), 32'd0);
        nextCycle();
        in_rst = 1'b1;

        $display("[TB] port 0 zero-wait read");
        applyStimulus(0, 1'b1, 32'h0000_0010, 1'b0, 32'd0);
        nextCycle();
        checkOutput("rd_htrans_c1", 32'(out_htrans), 32'd2);
        checkOutput("rd_hport_c1", 32'(out_hport), 32'b0011);
        checkOutput("rd_haddr_c1", out_haddr, 32'h0000_0010);
        checkOutput("rd_hsize_c1", 32'(out_hsize), 32'd2);
        applyStimulus(0, 1'b0, 32'd0, 1'b0, 32'd0);
        nextCycle();
        checkOutput("rd_htrans_c2", 32'(out_htrans), 32'd0);
        checkOutput("rd_ack_c2", 32'(out_m0_ack), 32'd0);
        nextCycle();
        checkOutput("rd_ack_c3", 32'(out_m0_ack), 32'd1);
        checkOutput("rd_rdata_c3", out_m0_rdata, 32'h1234_5678);
        checkOutput("rd_other_ack_c3", 32'({out_m1_ack, out_m0_err}), 32'd0);
        nextCycle();
        checkOutput("rd_ack_pulse", 32'(out_m0_ack), 32'd0);

        $display("[TB] port 1 write with two DATA wait states");
        applyStimulus(1, 1'b1, 32'h2000_0004, 1'b1, 32'hDEAD_BEEF);
        nextCycle();
        checkOutput("wr_htrans_c1", 32'(out_htrans), 32'd2);
        checkOutput("wr_hport_c1", 32'(out_hport), 32'b0001);
        checkOutput("wr_hwrite_c1", 32'(out_hwrite), 32'd1);
        checkOutput("wr_haddr_c1", out_haddr, 32'h2000_0004);
        applyStimulus(1, 1'b0, 32'd0, 1'b0, 32'd0);
        for (int c = 2; c <= 4; c++) begin
            nextCycle();
            checkOutput($sformatf("wr_hwdata_c%0d", c), out_hwdata, 32'hDEAD_BEEF);
            checkOutput($sformatf("wr_ack_c%0d", c), 32'(out_m1_ack), 32'd0);
            in_hready = (c == 4);
        end
        nextCycle();
        checkOutput("wr_ack_c5", 32'(out_m1_ack), 32'd1);
        checkOutput("wr_err_c5", 32'(out_m1_err), 32'd0);
        checkOutput("wr_rdata_c5", out_m1_rdata, 32'd0);
        checkOutput("wr_hwdata_c5", out_hwdata, 32'd0);
        checkOutput("wr_owner_c5", 32'(out_owner), 32'd1);

        $display("[TB] error response on port 0");
        applyStimulus(0, 1'b1, 32'h0000_0040, 1'b0, 32'd0);
        nextCycle();
        applyStimulus(0, 1'b0, 32'd0, 1'b0, 32'd0);
        nextCycle();
        in_hready = 1'b0; in_hresp = 1'b1;
        nextCycle();
        checkOutput("err_ack_first_cycle", 32'(out_m0_ack), 32'd0);
        in_hready = 1'b1;
        nextCycle();
        checkOutput("err_ack", 32'(out_m0_ack), 32'd1);
        checkOutput("err_flag", 32'(out_m0_err), 32'd1);
        in_hresp = 1'b0;
        nextCycle();

        $display("[TB] fixed priority with starvation guard");
        in_m0_size = 3'd1;
        applyStimulus(0, 1'b1, 32'h0000_0100, 1'b0, 32'd0);
        applyStimulus(1, 1'b1, 32'h0000_0200, 1'b0, 32'd0);
        nGrants = 0;
        for (int cyc = 0; cyc < 40 && nGrants < 7; cyc++) begin
            nextCycle();
            if (out_htrans == 2'b10) begin
                checkOutput($sformatf("starve_owner_%0d", nGrants), 32'(out_owner), 32'(starveExp[nGrants]));
                checkOutput($sformatf("starve_haddr_%0d", nGrants), out_haddr,
                            starveExp[nGrants] ? 32'h0000_0200 : 32'h0000_0100);
                checkOutput($sformatf("starve_hsize_%0d", nGrants), 32'(out_hsize),
                            starveExp[nGrants] ? 32'd2 : 32'd1);
                nGrants++;
            end
        end
        checkOutput("starve_grant_count", 32'(nGrants), 32'd7);
        applyStimulus(0, 1'b0, 32'd0, 1'b0, 32'd0);
        applyStimulus(1, 1'b0, 32'd0, 1'b0, 32'd0);
        in_m0_size = 3'd2;
        repeat (4) nextCycle();

        $display("[TB] round-robin alternation");
        in_m0_addr = 32'h0000_0300; in_m1_addr = 32'h0000_0400;
        rr_m0_req = 1'b1; rr_m1_req = 1'b1;
        nGrants = 0;
        for (int cyc = 0; cyc < 30 && nGrants < 4; cyc++) begin
            nextCycle();
            if (rr_htrans == 2'b10) begin
                checkOutput($sformatf("rr_owner_%0d", nGrants), 32'(rr_owner), 32'(rrExp[nGrants]));
                checkOutput($sformatf("rr_hport_%0d", nGrants), 32'(rr_hport),
                            rrExp[nGrants] ? 32'b0001 : 32'b0011);
                nGrants++;
            end
        end
        checkOutput("rr_grant_count", 32'(nGrants), 32'd4);
        rr_m0_req = 1'b0; rr_m1_req = 1'b0;
        repeat (4) nextCycle();

        $display("[TB] asynchronous reset during ADDR");
        in_hready = 1'b0;
        applyStimulus(1, 1'b1, 32'h0000_0500, 1'b0, 32'd0);
        nextCycle();
        checkOutput("rst_pre_htrans", 32'(out_htrans), 32'd2);
        #2 in_rst = 1'b0;
        #1;
        checkOutput("rst_async_htrans", 32'(out_htrans), 32'd0);
        checkOutput("rst_async_haddr", out_haddr, 32'd0);
        checkOutput("rst_async_hport", 32'(out_hport), 32'd0);
        checkOutput("rst_async_owner", 32'(out_owner), 32'd0);
        in_hready = 1'b1;
        nextCycle();
        checkOutput("rst_no_ack", 32'({out_m0_ack, out_m1_ack}), 32'd0);
        in_rst = 1'b1;
        nextCycle();
        checkOutput("rst_regrant_htrans", 32'(out_htrans), 32'd2);
        checkOutput("rst_regrant_owner", 32'(out_owner), 32'd1);
        applyStimulus(1, 1'b0, 32'd0, 1'b0, 32'd0);
        repeat (2) nextCycle();
        checkOutput("rst_regrant_ack", 32'(out_m1_ack), 32'd1);
        nextCycle();

        $display("[TB] grants blocked while init_done low");
        in_init_done = 1'b0;
        applyStimulus(0, 1'b1, 32'h0000_0600, 1'b0, 32'd0);
        for (int c = 0; c < 4; c++) begin
            nextCycle();
            checkOutput($sformatf("init_block_htrans_%0d", c), 32'(out_htrans), 32'd0);
        end
        in_init_done = 1'b1;
        nextCycle();
        checkOutput("init_release_htrans", 32'(out_htrans), 32'd2);
        checkOutput("init_release_owner", 32'(out_owner), 32'd0);
        applyStimulus(0, 1'b0, 32'd0, 1'b0, 32'd0);
        repeat (3) nextCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
